alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit ALU (ops ADD, SUB, AND, OR; flags N Z C V). It accepts one operation at a time from either requester over a valid/ready handshake, registers the operands, and evaluates them on one internal ALU instance. It then returns the registered result and flags to the requester that issued the operation. It sits between two issue sources (e.g. main datapath and an address/loop unit) and the single ALU resource.

## Interface
Parameters:
- WIDTH, 32, operand/result width; the ALU is fixed at 32, so only 32 is supported.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset (sampled on rising clk).
- req_valid  in  2  bit i: requester i presents an operation.
- req_ready  out  2  bit i: requester i's operation is accepted this cycle.
- req_a0, req_b0  in  32 each  requester 0 operands.
- req_op0  in  2  requester 0 op: 00 ADD, 01 SUB (a-b), 10 AND, 11 OR.
- req_a1, req_b1, req_op1  in  32/32/2  requester 1 equivalents.
- rsp_valid  out  2  bit i: response for requester i is on rsp_result/rsp_flags.
- rsp_ready  in  2  bit i: requester i consumes the response.
- rsp_result  out  32  registered ALU result.
- rsp_flags  out  4  registered flags: [3] N, [2] Z, [1] C, [0] V.
- busy  out  1  high in EXEC or RESP.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = arbitration winner among asserted req_valid bits.
  - req_ready[grant] = 1; all other req_ready bits = 0.
  - On req_valid[g] & req_ready[g]: latch a, b, op and owner id = g; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC: the ALU evaluates the latched operands. Capture result and flags into rsp_result/rsp_flags, then go to RESP.
- RESP: rsp_valid[owner] = 1, and the result and flags are held stable. On rsp_ready[owner], go to IDLE and update the arbitration pointer.
- req_ready is 0 in EXEC and RESP, and rsp_valid is 0 outside RESP.
- rsp_ready of the non-owner is ignored.
- Arithmetic:
  - SUB = a + ~b + 1.
  - C is carry-out for ADD/SUB (SUB C=1 means no borrow) and 0 for AND/OR.
  - V is signed overflow.
  - Z = (result == 0); N = result[31].
  - Results wrap modulo 2^32.
- Requesters must hold operands and op stable while valid and not ready. The arbiter does not check this.
- Reset:
  - state IDLE, req_ready 00, rsp_valid 00, rsp_result 0, rsp_flags 0, busy 0, pointer = requester 0.
  - Reset in EXEC or RESP discards the in-flight operation; no response is issued.

## Timing
- Accept at edge E0. rsp_valid rises after edge E1, i.e. two cycles after req_valid is first seen in IDLE.
- rsp_valid holds until the edge where rsp_ready[owner] = 1.
- Next accept occurs no earlier than the cycle after that edge. Peak throughput is one operation per 3 cycles.
- req_ready is combinational from state, pointer and req_valid. There are no combinational paths from rsp_ready to any output.
- Simultaneous req_valid = 11: only the pointer-selected requester sees ready. The other waits.
- A requester asserting valid in the same cycle its response retires is not accepted until the next IDLE cycle.

## Configuration
- ALU_ARB_RR_EN defined:
  - Round-robin arbitration. After a response retires, the pointer moves to the other requester, so the last-served requester has lowest priority.
  - Under continuous 11 requests, grants alternate 0,1,0,1.
- Undefined:
  - Fixed priority: requester 0 always wins a tie and the pointer is unused.
  - Requester 1 can starve under continuous requester 0 traffic.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with req_valid=11.
  - Required: req_ready=00, rsp_valid=00, rsp_result=0, rsp_flags=0, busy=0.
  - After release, requester 0 is granted first.
- Requester 0 ADD a=5, b=3, rsp_ready=1: rsp_valid=01 two cycles after accept, result 0x00000008, flags 0000. busy high for exactly 2 cycles.
- Requester 1 SUB a=3, b=3: result 0, flags 0110.
- Requester 1 ADD 0x7FFFFFFF+1: result 0x80000000, flags 1001.
- Requester 0 AND 0xF0F0F0F0 & 0xFF00FF00: result 0xF000F000, flags 1000.
- Requester 0 SUB with rsp_ready held 0 for 5 cycles:
  - rsp_valid and the result stay stable, and req_ready stays 00.
  - A reset pulse in RESP clears rsp_valid with no response delivered.
- Both requesters continuous with ALU_ARB_RR_EN: grants alternate 0,1,0,1.
  - Without the macro: all grants go to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester arbiter and sequencer in front of one shared 32-bit ALU
// (ADD, SUB, AND, OR with N/Z/C/V flags). One operation is in flight at a
// time. The winning request is accepted in IDLE. Its operands are evaluated
// in EXEC. The registered result is then offered to the issuing requester in
// RESP until that requester takes it.
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin between the two requesters
//                  undefined -> fixed priority, requester 0 wins ties
//
// Parameters:
//   WIDTH       operand/result width (only 32 is supported)
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous active-low reset
//   req_valid   [1:0] per-requester operation valid
//   req_ready   [1:0] per-requester accept (combinational, IDLE only)
//   req_a0/b0   requester 0 operands, req_op0 requester 0 opcode
//   req_a1/b1   requester 1 operands, req_op1 requester 1 opcode
//                 opcodes: 00 ADD, 01 SUB (a-b), 10 AND, 11 OR
//   rsp_valid   [1:0] response valid for the owning requester (registered)
//   rsp_ready   [1:0] per-requester response consume
//   rsp_result  registered ALU result
//   rsp_flags   registered flags {N, Z, C, V}
//   busy        high while an operation is in EXEC or RESP (registered)
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [1:0]       req_op0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_op1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;
    logic             grant_s;
    logic [WIDTH+3:0] alu_out_s;
`ifdef ALU_ARB_RR_EN
    logic             ptr_q, ptr_d;
`endif

    // ALU: returns {result, N, Z, C, V}. SUB is a + ~b + 1, so C=1 means no borrow.
    function automatic logic [WIDTH+3:0] alu_eval(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [1:0]       op
    );
        logic [WIDTH:0]   sum;
        logic [WIDTH-1:0] b_eff;
        logic [WIDTH-1:0] res;
        logic             c;
        logic             v;
        b_eff = (op == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, (op == OP_SUB)};
        res   = {WIDTH{1'b0}};
        c     = 1'b0;
        v     = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                // Overflow: both addends share a sign that the result lacks.
                v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            default: res = {WIDTH{1'b0}};
        endcase
        return {res, res[WIDTH-1], (res == {WIDTH{1'b0}}), c, v};
    endfunction

    // Arbitration winner among the asserted request bits.
    always_comb begin
        grant_s = 1'b0;
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant_s = ptr_q;
`else
            grant_s = 1'b0;
`endif
        end else if (req_valid[1]) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Accept strobe; also held low while reset is asserted so nothing is offered.
    always_comb begin
        req_ready = 2'b00;
        if (reset_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
            req_ready[grant_s] = 1'b1;
        end else begin
            req_ready = 2'b00;
        end
    end

    assign alu_out_s = alu_eval(a_q, b_q, op_q);

    // Next-state logic for the sequencer and its registered outputs.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        flags_d     = flags_q;
`ifdef ALU_ARB_RR_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid[grant_s]) begin
                    owner_d = grant_s;
                    a_d     = grant_s ? req_a1  : req_a0;
                    b_d     = grant_s ? req_b1  : req_b0;
                    op_d    = grant_s ? req_op1 : req_op0;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = alu_out_s[WIDTH+3:4];
                flags_d  = alu_out_s[3:0];
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
`ifdef ALU_ARB_RR_EN
                    // Last-served requester drops to lowest priority.
                    ptr_d   = ~owner_q;
`endif
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d      = (state_d != IDLE);
        rsp_valid_d = 2'b00;
        if (state_d == RESP) begin
            rsp_valid_d[owner_d] = 1'b1;
        end else begin
            rsp_valid_d = 2'b00;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            op_q        <= 2'b00;
            result_q    <= {WIDTH{1'b0}};
            flags_q     <= 4'b0000;
            rsp_valid_q <= 2'b00;
            busy_q      <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
`ifdef ALU_ARB_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = result_q;
    assign rsp_flags  = flags_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]  req_op0, req_op1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_op0    (req_op0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .req_op1    (req_op1),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction from a single requester with rsp_ready asserted.
    task automatic run_op(input int who, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_res,
                          input logic [3:0] exp_flg, input string tag);
        logic [1:0] mask;
        mask = (who == 1) ? 2'b10 : 2'b01;
        if (who == 1) begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end else begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end
        req_valid = mask;
        rsp_ready = mask;
        #1;
        chk({tag, "_ready"}, {62'd0, req_ready}, {62'd0, mask});
        tick();
        req_valid = 2'b00;
        chk({tag, "_exec_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_exec_rspv"}, {62'd0, rsp_valid}, 64'd0);
        tick();
        chk({tag, "_rspv"}, {62'd0, rsp_valid}, {62'd0, mask});
        chk({tag, "_result"}, {32'd0, rsp_result}, {32'd0, exp_res});
        chk({tag, "_flags"}, {60'd0, rsp_flags}, {60'd0, exp_flg});
        tick();
        chk({tag, "_done_rspv"}, {62'd0, rsp_valid}, 64'd0);
        chk({tag, "_done_busy"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        logic [1:0] exp_g;
        reset_n   = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b00;
        req_a0 = 32'd5; req_b0 = 32'd3; req_op0 = 2'b00;
        req_a1 = 32'd9; req_b1 = 32'd9; req_op1 = 2'b01;

        // Reset held two cycles with both requesters valid.
        tick();
        tick();
        chk("rst_ready",  {62'd0, req_ready}, 64'd0);
        chk("rst_rspv",   {62'd0, rsp_valid}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_flags",  {60'd0, rsp_flags}, 64'd0);
        chk("rst_busy",   {63'd0, busy}, 64'd0);

        // Release: requester 0 wins first; ADD 5+3.
        reset_n   = 1'b1;
        rsp_ready = 2'b01;
        #1;
        chk("first_grant", {62'd0, req_ready}, 64'd1);
        tick();
        req_valid = 2'b00;
        chk("add_exec_busy", {63'd0, busy}, 64'd1);
        chk("add_exec_ready", {62'd0, req_ready}, 64'd0);
        chk("add_exec_rspv", {62'd0, rsp_valid}, 64'd0);
        tick();
        chk("add_rspv",   {62'd0, rsp_valid}, 64'd1);
        chk("add_result", {32'd0, rsp_result}, 64'h8);
        chk("add_flags",  {60'd0, rsp_flags}, 64'd0);
        chk("add_resp_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("add_done_busy", {63'd0, busy}, 64'd0);
        chk("add_done_rspv", {62'd0, rsp_valid}, 64'd0);

        run_op(1, 32'd3, 32'd3, 2'b01, 32'h0000_0000, 4'b0110, "sub_zero");
        run_op(1, 32'h7FFF_FFFF, 32'd1, 2'b00, 32'h8000_0000, 4'b1001, "add_ovf");
        run_op(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 2'b10, 32'hF000_F000, 4'b1000, "and");
        run_op(0, 32'h0000_00F0, 32'h0000_000F, 2'b11, 32'h0000_00FF, 4'b0000, "or");
        run_op(1, 32'd2, 32'd5, 2'b01, 32'hFFFF_FFFD, 4'b1000, "sub_borrow");

        // Stall: requester 0 SUB 10-3, response withheld for 5 cycles.
        req_a0 = 32'd10; req_b0 = 32'd3; req_op0 = 2'b01;
        req_valid = 2'b01;
        rsp_ready = 2'b00;
        tick();
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        rsp_ready = 2'b10;   // non-owner ready must be ignored
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_rspv",   {62'd0, rsp_valid}, 64'd1);
            chk("stall_result", {32'd0, rsp_result}, 64'd7);
            chk("stall_flags",  {60'd0, rsp_flags}, 64'b0010);
            chk("stall_ready",  {62'd0, req_ready}, 64'd0);
        end

        // Reset pulse while in RESP discards the response.
        reset_n   = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b01;
        tick();
        reset_n = 1'b1;
        chk("rstpulse_rspv",   {62'd0, rsp_valid}, 64'd0);
        chk("rstpulse_result", {32'd0, rsp_result}, 64'd0);
        chk("rstpulse_busy",   {63'd0, busy}, 64'd0);
        tick();
        chk("rstpulse_quiet",  {62'd0, rsp_valid}, 64'd0);

        // Both requesters continuously valid; observe grant order.
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 2'b00;
        req_a1 = 32'd4; req_b1 = 32'd1; req_op1 = 2'b01;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        #1;
        for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_RR_EN
            exp_g = (n % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            chk("contend_grant", {62'd0, req_ready}, {62'd0, exp_g});
            tick();
            tick();
            chk("contend_result", {32'd0, rsp_result},
                (exp_g == 2'b10) ? 64'd3 : 64'd2);
            tick();
        end

        req_valid = 2'b00;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
